// File: rtl/i2c_target_responder.sv
// I2C target that answers a single 7-bit address: ACKs every write byte and
// streams TxData on reads. Bus pins are oversampled on the system clock.
module i2c_target_responder #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h48
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_pull_low,
  input  logic [7:0] TxData,
  output logic       TxLoad,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       Busy,
  output logic       RW
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  logic   scl_meta_q, scl_sync_q, scl_prev_q;
  logic   sda_meta_q, sda_sync_q, sda_prev_q;
  logic   scl_rise_s, scl_fall_s, start_s, stop_s, load_tx_s;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_done_q, byte_done_d;
  logic       pull_q, pull_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  // Two-flop synchronizers plus a delayed copy for edge detection; idle bus is high.
  always_ff @(posedge clock) begin
    if (Reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= SCL_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= SDA_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise_s = scl_sync_q & ~scl_prev_q;
  assign scl_fall_s = ~scl_sync_q & scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
  assign start_s = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_s  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

  // Next-state and output computation; START/STOP override any SCL edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    byte_done_d  = byte_done_q;
    pull_d       = pull_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    tx_load_d    = 1'b0;
    busy_d       = busy_q;
    rw_d         = rw_q;
    load_tx_s    = 1'b0;
    if (stop_s) begin
      state_d     = IDLE;
      pull_d      = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
    end else if (start_s) begin
      state_d     = ADDR;
      pull_d      = 1'b0;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
      shift_d     = 8'h00;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise_s && !byte_done_q) begin
            shift_d = {shift_q[6:0], sda_sync_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_q[6:0] == DEVICE_ADDRESS) begin
                rw_d        = sda_sync_q;
                busy_d      = 1'b1;
                byte_done_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              byte_done_d = 1'b0;
            end
          end else if (scl_fall_s && byte_done_q) begin
            byte_done_d = 1'b0;
            pull_d      = 1'b1;
            state_d     = ADDR_ACK;
          end else begin
            state_d = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            if (rw_q) begin
              load_tx_s = 1'b1;
            end else begin
              pull_d  = 1'b0;
              state_d = WR_DATA;
            end
          end else begin
            state_d = ADDR_ACK;
          end
        end
        WR_DATA: begin
          if (scl_rise_s && !byte_done_q) begin
            shift_d = {shift_q[6:0], sda_sync_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              byte_done_d  = 1'b1;
              data_out_d   = {shift_q[6:0], sda_sync_q};
              data_valid_d = 1'b1;
            end else begin
              byte_done_d = 1'b0;
            end
          end else if (scl_fall_s && byte_done_q) begin
            byte_done_d = 1'b0;
            pull_d      = 1'b1;
            state_d     = WR_ACK;
          end else begin
            state_d = WR_DATA;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            pull_d  = 1'b0;
            state_d = WR_DATA;
          end else begin
            state_d = WR_ACK;
          end
        end
        RD_DATA: begin
          if (scl_fall_s) begin
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              pull_d  = 1'b0;
              state_d = RD_ACK;
            end else begin
              cnt_d   = cnt_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              pull_d  = ~shift_q[6];
            end
          end else begin
            state_d = RD_DATA;
          end
        end
        RD_ACK: begin
          if (scl_rise_s) begin
            if (sda_sync_q) begin
              state_d = IGNORE;
            end else begin
              byte_done_d = 1'b1;
            end
          end else if (scl_fall_s && byte_done_q) begin
            byte_done_d = 1'b0;
            load_tx_s   = 1'b1;
          end else begin
            state_d = RD_ACK;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    // Shared reload path used after the address ACK and after each controller ACK.
    if (load_tx_s) begin
      shift_d   = TxData;
      tx_load_d = 1'b1;
      pull_d    = ~TxData[7];
      cnt_d     = 3'd0;
      state_d   = RD_DATA;
    end else begin
      tx_load_d = 1'b0;
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 8'h00;
      byte_done_q  <= 1'b0;
      pull_q       <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      tx_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      byte_done_q  <= byte_done_d;
      pull_q       <= pull_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      tx_load_q    <= tx_load_d;
      busy_q       <= busy_d;
      rw_q         <= rw_d;
    end
  end

  assign SDA_pull_low = pull_q;
  assign TxLoad       = tx_load_q;
  assign DataOut      = data_out_q;
  assign DataValid    = data_valid_q;
  assign Busy         = busy_q;
  assign RW           = rw_q;

endmodule
